// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between the IF fetch port and the MEM load/store port.
// Optional macro ARB_FAIRNESS_EN bounds consecutive MEM grants while IF waits (MAX_MEM_STREAK).
module unified_mem_arbiter #(
   parameter int XLEN           = 32,
   parameter int MAX_MEM_STREAK = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   input  logic            if_flush,
   output logic [XLEN-1:0] if_rdata,
   output logic            if_valid,
   output logic            if_stall,
   input  logic            mem_req,
   input  logic            mem_we,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_rdata,
   output logic            mem_valid,
   output logic            mem_stall,
   output logic            ram_req,
   output logic            ram_we,
   output logic [XLEN-1:0] ram_addr,
   output logic [XLEN-1:0] ram_wdata,
   output logic [3:0]      ram_be,
   input  logic            ram_ready,
   input  logic [XLEN-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2
   } state_t;

   state_t state_r;
   logic   drop_r;
   logic   if_valid_s;
   logic   mem_valid_s;
   logic   fair_force_if_s;

   if (MAX_MEM_STREAK < 1) begin : g_bad_streak
      $error("MAX_MEM_STREAK must be >= 1");
   end

`ifdef ARB_FAIRNESS_EN
   localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);
   logic [STREAK_W-1:0] streak_r;
`endif

   // Completion strobes; a dropped or same-cycle-flushed fetch never reports valid
   always_comb begin
      if_valid_s  = 1'b0;
      mem_valid_s = 1'b0;
      if (state_r == GNT_IF) begin
         if_valid_s = ram_ready & ~drop_r & ~if_flush;
      end else if (state_r == GNT_MEM) begin
         mem_valid_s = ram_ready;
      end else begin
         if_valid_s  = 1'b0;
         mem_valid_s = 1'b0;
      end
   end

   // Fairness override: IF wins once MEM has used up its streak while IF waited
   always_comb begin
      fair_force_if_s = 1'b0;
`ifdef ARB_FAIRNESS_EN
      if (if_req && (streak_r == STREAK_MAX)) begin
         fair_force_if_s = 1'b1;
      end else begin
         fair_force_if_s = 1'b0;
      end
`endif
   end

   assign if_valid  = if_valid_s;
   assign mem_valid = mem_valid_s;
   assign if_rdata  = if_valid_s  ? ram_rdata : {XLEN{1'b0}};
   assign mem_rdata = mem_valid_s ? ram_rdata : {XLEN{1'b0}};
   assign if_stall  = if_req  & ~if_valid_s;
   assign mem_stall = mem_req & ~mem_valid_s;

   // Grant FSM with registered memory-side request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         drop_r    <= 1'b0;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= {XLEN{1'b0}};
         ram_wdata <= {XLEN{1'b0}};
         ram_be    <= 4'h0;
`ifdef ARB_FAIRNESS_EN
         streak_r  <= {STREAK_W{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (mem_req && !fair_force_if_s) begin
                  state_r   <= GNT_MEM;
                  ram_req   <= 1'b1;
                  ram_we    <= mem_we;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_wdata;
                  ram_be    <= mem_be;
`ifdef ARB_FAIRNESS_EN
                  if (!if_req) begin
                     streak_r <= {STREAK_W{1'b0}};
                  end else if (streak_r != STREAK_MAX) begin
                     streak_r <= streak_r + STREAK_W'(1);
                  end else begin
                     streak_r <= streak_r;
                  end
`endif
               end else if (if_req) begin
                  state_r   <= GNT_IF;
                  drop_r    <= 1'b0;
                  ram_req   <= 1'b1;
                  ram_we    <= 1'b0;
                  ram_addr  <= if_addr;
                  ram_wdata <= {XLEN{1'b0}};
                  ram_be    <= 4'hF;
`ifdef ARB_FAIRNESS_EN
                  streak_r  <= {STREAK_W{1'b0}};
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            GNT_IF: begin
               // A flushed fetch cannot be aborted; it completes silently
               if (ram_ready) begin
                  state_r <= IDLE;
                  ram_req <= 1'b0;
                  drop_r  <= 1'b0;
               end else if (if_flush) begin
                  drop_r <= 1'b1;
               end else begin
                  drop_r <= drop_r;
               end
            end
            GNT_MEM: begin
               if (ram_ready) begin
                  state_r <= IDLE;
                  ram_req <= 1'b0;
               end else begin
                  state_r <= GNT_MEM;
               end
            end
            default: begin
               state_r <= IDLE;
               ram_req <= 1'b0;
               drop_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (strict priority by default,
// fairness sequence when ARB_FAIRNESS_EN is defined).
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush;
   logic [31:0] if_addr, if_rdata;
   logic        if_valid, if_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_valid, mem_stall;
   logic        ram_req, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_be;
   logic        ram_ready;

   int n_chk  = 0;
   int n_fail = 0;

   unified_mem_arbiter #(.XLEN(32), .MAX_MEM_STREAK(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_be(ram_be),
      .ram_ready(ram_ready), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_be = 4'h0;
      ram_ready = 1'b0; ram_rdata = 32'h0;
      tick(); tick();
      n_chk++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req got %0h exp 0", ram_req); end
      n_chk++; if ({ram_we, ram_be, ram_addr, ram_wdata} !== 69'h0) begin n_fail++; $display("FAIL reset_ram_bus got we=%0h be=%0h addr=%0h wd=%0h exp 0", ram_we, ram_be, ram_addr, ram_wdata); end
      n_chk++; if ({if_valid, mem_valid, if_stall, mem_stall} !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {if_valid, mem_valid, if_stall, mem_stall}); end
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      if_req = 1'b1; if_addr = 32'h100; #1;
      n_chk++; if (if_stall !== 1'b1 || ram_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_cycle got stall=%0h req=%0h exp 1 0", if_stall, ram_req); end
      tick(); #1;
      n_chk++; if (ram_req !== 1'b1 || ram_addr !== 32'h100 || ram_be !== 4'hF || ram_we !== 1'b0) begin n_fail++; $display("FAIL fetch_grant got req=%0h addr=%0h be=%0h we=%0h exp 1 100 f 0", ram_req, ram_addr, ram_be, ram_we); end
      n_chk++; if (if_stall !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_wait1 got stall=%0h valid=%0h exp 1 0", if_stall, if_valid); end
      tick(); #1;
      n_chk++; if (if_stall !== 1'b1 || ram_req !== 1'b1) begin n_fail++; $display("FAIL fetch_wait2 got stall=%0h req=%0h exp 1 1", if_stall, ram_req); end
      tick(); ram_ready = 1'b1; ram_rdata = 32'h00500093; #1;
      n_chk++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_done got valid=%0h rdata=%0h stall=%0h exp 1 00500093 0", if_valid, if_rdata, if_stall); end
      n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_no_mem_valid got %0h exp 0", mem_valid); end
      tick(); if_req = 1'b0; ram_ready = 1'b0; #1;
      n_chk++; if (ram_req !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_after got req=%0h valid=%0h rdata=%0h exp 0 0 0", ram_req, if_valid, if_rdata); end
   endtask

   task automatic test_store_zero_wait();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_be = 4'b0011; #1;
      n_chk++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL store_req_stall got %0h exp 1", mem_stall); end
      tick(); ram_ready = 1'b1; ram_rdata = 32'h0; #1;
      n_chk++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h2000 || ram_wdata !== 32'hDEADBEEF || ram_be !== 4'b0011) begin n_fail++; $display("FAIL store_bus got req=%0h we=%0h addr=%0h wd=%0h be=%0h exp 1 1 2000 deadbeef 3", ram_req, ram_we, ram_addr, ram_wdata, ram_be); end
      n_chk++; if (mem_valid !== 1'b1 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL store_done got valid=%0h stall=%0h exp 1 0", mem_valid, mem_stall); end
      tick(); mem_req = 1'b0; #1;
      n_chk++; if (ram_req !== 1'b0 || mem_valid !== 1'b0 || mem_rdata !== 32'h0) begin n_fail++; $display("FAIL store_idle_ready got req=%0h valid=%0h rdata=%0h exp 0 0 0", ram_req, mem_valid, mem_rdata); end
      tick(); ram_ready = 1'b0; mem_we = 1'b0;
   endtask

   task automatic test_priority();
      mem_req = 1'b1; mem_addr = 32'h3000; mem_be = 4'hF; if_req = 1'b1; if_addr = 32'h200; #1;
      tick(); #1;
      n_chk++; if (ram_req !== 1'b1 || ram_addr !== 32'h3000 || ram_we !== 1'b0) begin n_fail++; $display("FAIL prio_mem_first got req=%0h addr=%0h we=%0h exp 1 3000 0", ram_req, ram_addr, ram_we); end
      n_chk++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL prio_stalls got if=%0h mem=%0h exp 1 1", if_stall, mem_stall); end
      tick(); ram_ready = 1'b1; ram_rdata = 32'h11223344; #1;
      n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h11223344 || if_valid !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL prio_load got mv=%0h rd=%0h iv=%0h is=%0h exp 1 11223344 0 1", mem_valid, mem_rdata, if_valid, if_stall); end
      tick(); mem_req = 1'b0; ram_ready = 1'b0; #1;
      n_chk++; if (ram_req !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL prio_turnaround got req=%0h is=%0h exp 0 1", ram_req, if_stall); end
      tick(); ram_ready = 1'b1; ram_rdata = 32'hAAAA5555; #1;
      n_chk++; if (ram_addr !== 32'h200 || ram_be !== 4'hF || if_valid !== 1'b1 || if_rdata !== 32'hAAAA5555) begin n_fail++; $display("FAIL prio_fetch got addr=%0h be=%0h iv=%0h rd=%0h exp 200 f 1 aaaa5555", ram_addr, ram_be, if_valid, if_rdata); end
      tick(); if_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      if_req = 1'b1; if_addr = 32'h300;
      tick(); if_flush = 1'b1; if_addr = 32'h40; #1;
      n_chk++; if (ram_addr !== 32'h300 || if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_grant got addr=%0h iv=%0h exp 300 0", ram_addr, if_valid); end
      tick(); if_flush = 1'b0;
      tick();
      tick(); ram_ready = 1'b1; ram_rdata = 32'h00000BAD; #1;
      n_chk++; if (ram_req !== 1'b1 || if_valid !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL flush_drop got req=%0h iv=%0h is=%0h exp 1 0 1", ram_req, if_valid, if_stall); end
      tick(); ram_ready = 1'b0; #1;
      n_chk++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle got req=%0h exp 0", ram_req); end
      tick(); ram_ready = 1'b1; ram_rdata = 32'h00000013; #1;
      n_chk++; if (ram_addr !== 32'h40 || if_valid !== 1'b1 || if_rdata !== 32'h00000013) begin n_fail++; $display("FAIL flush_refetch got addr=%0h iv=%0h rd=%0h exp 40 1 13", ram_addr, if_valid, if_rdata); end
      // flush coinciding with ready: suppressed, but no drop carried forward
      tick(); ram_ready = 1'b0; if_addr = 32'h500;
      tick(); ram_ready = 1'b1; if_flush = 1'b1; ram_rdata = 32'h55; #1;
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle got iv=%0h exp 0", if_valid); end
      tick(); ram_ready = 1'b0; if_flush = 1'b0;
      tick(); ram_ready = 1'b1; ram_rdata = 32'h66; #1;
      n_chk++; if (if_valid !== 1'b1 || if_rdata !== 32'h66) begin n_fail++; $display("FAIL flush_no_stale_drop got iv=%0h rd=%0h exp 1 66", if_valid, if_rdata); end
      tick(); if_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h44; mem_wdata = 32'h5; mem_be = 4'hF;
      tick(); #1;
      n_chk++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre got req=%0h exp 1", ram_req); end
      rst_n = 1'b0; mem_req = 1'b0; #1;
      n_chk++; if ({ram_req, ram_we, ram_be, ram_addr, ram_wdata} !== 70'h0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL areset_clear got req=%0h we=%0h be=%0h addr=%0h wd=%0h mv=%0h exp 0", ram_req, ram_we, ram_be, ram_addr, ram_wdata, mem_valid); end
      tick(); #2 rst_n = 1'b1;
      tick(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h88;
      tick(); #1;
      n_chk++; if (ram_req !== 1'b1 || ram_addr !== 32'h88 || ram_we !== 1'b0) begin n_fail++; $display("FAIL areset_restart got req=%0h addr=%0h we=%0h exp 1 88 0", ram_req, ram_addr, ram_we); end
      ram_ready = 1'b1;
      tick(); mem_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g [6];
      logic [1:0] got_g [6];
      int ng = 0;
`ifdef ARB_FAIRNESS_EN
      exp_g = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
`else
      exp_g = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
      mem_req = 1'b1; if_req = 1'b1; ram_ready = 1'b1; ram_rdata = 32'h7;
      for (int c = 0; c < 30 && ng < 6; c++) begin
         tick(); #1;
         n_chk++; if (if_valid === 1'b1 && mem_valid === 1'b1) begin n_fail++; $display("FAIL b2b_both_valid got iv=1 mv=1 exp not both"); end
         if (mem_valid === 1'b1) begin got_g[ng] = 2'd1; ng++; end
         else if (if_valid === 1'b1) begin got_g[ng] = 2'd2; ng++; end
      end
      n_chk++; if (ng != 6) begin n_fail++; $display("FAIL b2b_timeout got %0d grants exp 6", ng); end
      for (int i = 0; i < ng; i++) begin
         n_chk++; if (got_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL b2b_order[%0d] got %0d exp %0d (1=MEM 2=IF)", i, got_g[i], exp_g[i]); end
      end
      mem_req = 1'b0; if_req = 1'b0; ram_ready = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store_zero_wait();
      test_priority();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline. Sequences each access with a req/ready handshake and generates the stall signals for both stages. Handles a fetch flush from branch/jump redirects that arrives while a fetch is still in flight. Sits between the pipeline stages and the memory model, alongside hazard detection.

Parameters:
XLEN, 32, data/address width
MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF is waiting (used only with ARB_FAIRNESS_EN; must be >=1)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset: asynchronous, active-low
if_req  in  1  fetch request; held with if_addr stable while if_stall=1
if_addr  in  XLEN  fetch address
if_flush  in  1  branch/jump redirect; discard any in-flight fetch
if_rdata  out  XLEN  fetched instruction, valid when if_valid=1
if_valid  out  1  fetch complete this cycle
if_stall  out  1  stall PC/IF_ID
mem_req  in  1  load/store request; held stable while mem_stall=1
mem_we  in  1  1=store
mem_addr  in  XLEN  data address
mem_wdata  in  XLEN  store data
mem_be  in  4  byte enables
mem_rdata  out  XLEN  load data, valid when mem_valid=1
mem_valid  out  1  data access complete this cycle
mem_stall  out  1  stall the pipeline at MEM
ram_req  out  1  memory request, registered
ram_we  out  1  registered
ram_addr  out  XLEN  registered
ram_wdata  out  XLEN  registered
ram_be  out  4  registered; 4'hF for fetches
ram_ready  in  1  memory done this cycle; ram_rdata valid
ram_rdata  in  XLEN  memory read data

Behaviour:
- FSM states: IDLE, GNT_IF, GNT_MEM.
- IDLE: if mem_req, go to GNT_MEM. Else if if_req, go to GNT_IF. Otherwise stay.
- On the grant edge, latch the winner's address, wdata, we and be into the ram_* registers, and set ram_req=1. A fetch drives ram_we=0 and ram_be=4'hF.
- GNT_x: hold ram_* stable until ram_ready=1. On that ready cycle:
  - x_valid=1 combinationally and x_rdata=ram_rdata (pass-through).
  - Next state is IDLE. ram_req clears at that edge.
- Latency: request seen in IDLE at cycle N, ram_req=1 at N+1. With zero-wait memory (ready at N+1), valid occurs at N+1. Minimum 2 cycles per access; one IDLE turnaround between back-to-back accesses.
- Stalls, combinational:
  - if_stall = if_req & ~if_valid.
  - mem_stall = mem_req & ~mem_valid.
  - A requester not granted stays stalled.
- ram_ready outside GNT_x is ignored.
- if_valid and mem_valid are never both 1.
- Flush in GNT_IF before ram_ready: the transaction cannot be aborted.
  - Set a drop flag and keep ram_req until ready.
  - On ready, force if_valid=0 and clear the drop flag; go to IDLE.
  - The redirected fetch is re-arbitrated from IDLE.
- Flush in the same cycle as ram_ready in GNT_IF: if_valid=0, no drop flag set.
- Flush in IDLE or GNT_MEM: no effect on state.
- Simultaneous mem_req and if_req in IDLE: MEM wins (older instruction).
- Reset (async, any time, including mid-transaction):
  - Go to IDLE; ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_be=0.
  - Clear the drop flag and the streak counter.
  - The in-flight access is abandoned.
  - if_valid=0, mem_valid=0, and rdata outputs are 0 while in IDLE.

Optional Feature:
Macro ARB_FAIRNESS_EN.
- Defined: a streak counter of $clog2(MAX_MEM_STREAK+1) bits.
  - Increments on each MEM grant made while if_req=1, saturating at MAX_MEM_STREAK.
  - Clears on any IF grant, and on a MEM grant made while if_req=0.
  - In IDLE, when the counter equals MAX_MEM_STREAK and if_req=1, IF wins over MEM.
- Undefined: strict MEM priority, no counter logic.

Test Plan:
- Single fetch, ready 2 cycles after ram_req, if_addr=0x100, ram_rdata=0x00500093 -> ram_addr=0x100, ram_be=4'hF, if_stall=1 until the if_valid cycle, if_rdata=0x00500093, ram_req drops the next cycle.
- Store with zero-wait memory, mem_addr=0x2000, mem_wdata=0xDEADBEEF, mem_be=4'b0011 -> ram_we=1 with those values, mem_valid one cycle after grant, mem_stall=1 only in the request cycle and the grant cycle before it.
- if_req and mem_req both asserted in IDLE -> GNT_MEM first. Fetch granted after one IDLE cycle; if_stall=1 throughout the load.
- if_flush pulsed mid-fetch (ready 3 cycles late) -> ram_req held until ready, if_valid stays 0, then a new fetch of the redirected address 0x40 is issued.
- rst_n dropped while ram_req=1 in GNT_MEM -> ram_req=0 and all outputs 0 immediately (asynchronous). After release, arbitration restarts from IDLE.
- (ARB_FAIRNESS_EN, MAX_MEM_STREAK=2) mem_req and if_req both held continuously -> grant order MEM, MEM, IF, MEM, MEM, IF. Without the macro -> MEM only while mem_req stays high.
